codec_frame_timer: RTL and testbench
====================================

// Module: codec_frame_timer
// PURPOSE
//  Parametrised serial-audio timing generator for the WM8731 codec interface.
//  Divides clk into bit phases, counts phases/bits/channels, and emits BCLK, LRCLK and strobes.
//  Supports I2S, left-justified and DSP framing.
//  Sits between the system clock and the codec shift registers; the shifters use phase/nbit/chan.
// PARAMETERS
//  DIV          125  clk cycles per phase (>=2)
//  PHASES       4    phases per serial bit (even, >=2); bclk low for first PHASES/2 phases
//  BITS_PER_CH  16   serial bits per channel slot (>=2)
//  CHANNELS     2    channel slots per frame (>=2)
//  Derived widths: DW=$clog2(DIV), PW=max(1,$clog2(PHASES)), BW=max(1,$clog2(BITS_PER_CH)), CW=max(1,$clog2(CHANNELS))
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  reset        in   1   synchronous, active-low reset
//  en           in   1   1=run, 0=freeze all counters and outputs
//  mode         in   2   0=I2S, 1=left-justified, 2=DSP pulse, 3=reserved (treated as 1)
//  phase        out  PW  current phase within bit, 0..PHASES-1
//  nbit         out  BW  current bit within slot, 0..BITS_PER_CH-1
//  chan         out  CW  current channel slot, 0..CHANNELS-1
//  phase_stb    out  1   1-cycle pulse on each phase advance
//  frame_start  out  1   1-cycle pulse when counters wrap to phase=0,nbit=0,chan=0
//  bclk         out  1   serial bit clock
//  lrclk        out  1   frame/word clock
//  mode_act     out  2   mode currently in effect
// BEHAVIOUR
//  - Reset (reset==0 at posedge): prescaler=0, phase=nbit=chan=0, phase_stb=frame_start=0, bclk=0.
//    mode_act<=mode (3 mapped to 1). lrclk<=decode(all-zero state, that mode), i.e. 1 only for DSP.
//  - Prescaler: counts 0..DIV-1 while en=1. Tick when prescaler==DIV-1; prescaler then wraps to 0.
//    First tick after reset release occurs DIV enabled cycles later.
//  - On tick: phase<=phase+1 mod PHASES. On phase wrap, nbit<=nbit+1 mod BITS_PER_CH.
//    On nbit wrap, chan<=chan+1 mod CHANNELS. Explicit compare-and-clear; no reliance on power-of-2 overflow.
//  - All outputs registered. They update on the same edge as the counters and use next-state values.
//    Zero-latency relation: outputs always consistent with the current phase/nbit/chan.
//  - phase_stb=1 exactly on the cycle following a tick, else 0.
//  - frame_start=1 on that cycle only if the new state is all-zero.
//  - bclk = (phase >= PHASES/2).
//  - lrclk decode from (nbit,chan):
//    LJ  : 1 when chan is odd.
//    I2S : leads the slot by one bit: 1 when (chan odd XOR nbit==BITS_PER_CH-1).
//          Correction: take the next-bit channel's parity, so CHANNELS odd still alternates per slot.
//    DSP : 1 only while chan==0 && nbit==0.
//  - mode is sampled only at reset and on frame_start cycles. mode_act changes there; mid-frame mode changes are ignored.
//  - en=0: prescaler, counters, bclk, lrclk, mode_act hold; phase_stb and frame_start forced 0.
//    Resume continues from the held prescaler value, with no extra or lost tick.
//  - Reset mid-frame: immediate return to reset state on that edge; reset dominates en.
//  - Simultaneous wrap of phase, nbit and chan: single edge, frame_start=1, lrclk per new state.
// TESTING (bench params DIV=3, PHASES=4, BITS_PER_CH=4, CHANNELS=2 unless stated)
//  1. Reset, en=1, mode=1 -> phase_stb every 3 clk; bclk 0,0,1,1 per 12 clk; nbit steps each 12 clk;
//     chan toggles every 48 clk; frame_start every 96 clk.
//  2. mode=0 (I2S) -> lrclk rises when chan=0,nbit=3 and falls when chan=1,nbit=3; 12 clk ahead of chan change.
//  3. mode=2 (DSP) -> lrclk=1 only for the 12 clk with chan=0,nbit=0, including immediately out of reset.
//  4. Switch mode 1->2 at clk 30 -> mode_act stays 1 until first frame_start (clk 96), then 2.
//  5. Drop en for 7 clk mid-bit -> all outputs frozen, no strobes; next phase_stb lands 7 clk late, sequence intact.
//  6. Assert reset at chan=1,nbit=2 -> next edge all counters 0, bclk=0, lrclk=0 (mode 1).
//     Defaults (DIV=125) -> first phase_stb 125 clk after release.

Source files
------------

// File: rtl/codec_frame_timer.sv
// Serial-audio timing generator for a WM8731-style codec: prescales clk into bit phases,
// counts phase/bit/channel, and produces registered BCLK, LRCLK and timing strobes.
module codec_frame_timer #(
    parameter int DIV         = 125,
    parameter int PHASES      = 4,
    parameter int BITS_PER_CH = 16,
    parameter int CHANNELS    = 2,
    localparam int DW = $clog2(DIV),
    localparam int PW = ($clog2(PHASES) > 1) ? $clog2(PHASES) : 1,
    localparam int BW = ($clog2(BITS_PER_CH) > 1) ? $clog2(BITS_PER_CH) : 1,
    localparam int CW = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [1:0]    mode,
    output logic [PW-1:0] phase,
    output logic [BW-1:0] nbit,
    output logic [CW-1:0] chan,
    output logic          phase_stb,
    output logic          frame_start,
    output logic          bclk,
    output logic          lrclk,
    output logic [1:0]    mode_act
);

    localparam logic [1:0] MODE_I2S = 2'd0;
    localparam logic [1:0] MODE_LJ  = 2'd1;
    localparam logic [1:0] MODE_DSP = 2'd2;

    localparam logic [DW-1:0] PRESC_LAST = DW'(DIV - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(PHASES - 1);
    localparam logic [PW-1:0] PHASE_HIGH = PW'(PHASES / 2);
    localparam logic [BW-1:0] NBIT_LAST  = BW'(BITS_PER_CH - 1);
    localparam logic [CW-1:0] CHAN_LAST  = CW'(CHANNELS - 1);

    // The reserved encoding behaves as left-justified.
    function automatic logic [1:0] mode_map(input logic [1:0] md);
        logic [1:0] res;
        case (md)
            MODE_I2S: res = MODE_I2S;
            MODE_LJ:  res = MODE_LJ;
            MODE_DSP: res = MODE_DSP;
            default:  res = MODE_LJ;
        endcase
        return res;
    endfunction

    // I2S uses the parity of the channel owning the next bit, so odd CHANNELS still alternate.
    function automatic logic lrclk_decode(input logic [BW-1:0] nb,
                                          input logic [CW-1:0] ch,
                                          input logic [1:0]    md);
        logic [CW-1:0] ch_next;
        logic          res;
        ch_next = (ch == CHAN_LAST) ? {CW{1'b0}} : ch + CW'(1);
        case (md)
            MODE_I2S: res = (nb == NBIT_LAST) ? ch_next[0] : ch[0];
            MODE_DSP: res = (ch == {CW{1'b0}}) && (nb == {BW{1'b0}});
            default:  res = ch[0];
        endcase
        return res;
    endfunction

    logic [DW-1:0] presc_r;
    logic [PW-1:0] phase_r;
    logic [BW-1:0] nbit_r;
    logic [CW-1:0] chan_r;
    logic          phase_stb_r;
    logic          frame_start_r;
    logic          bclk_r;
    logic          lrclk_r;
    logic [1:0]    mode_act_r;

    logic          tick_s;
    logic          phase_wrap_s;
    logic          nbit_wrap_s;
    logic          chan_wrap_s;
    logic          frame_wrap_s;
    logic [DW-1:0] presc_nxt_s;
    logic [PW-1:0] phase_nxt_s;
    logic [BW-1:0] nbit_nxt_s;
    logic [CW-1:0] chan_nxt_s;
    logic [1:0]    mode_nxt_s;
    logic          bclk_nxt_s;
    logic          lrclk_nxt_s;

    // Next-state counters and the output values derived from them.
    always_comb begin
        tick_s       = en && (presc_r == PRESC_LAST);
        phase_wrap_s = (phase_r == PHASE_LAST);
        nbit_wrap_s  = (nbit_r == NBIT_LAST);
        chan_wrap_s  = (chan_r == CHAN_LAST);
        frame_wrap_s = tick_s && phase_wrap_s && nbit_wrap_s && chan_wrap_s;

        presc_nxt_s = presc_r;
        phase_nxt_s = phase_r;
        nbit_nxt_s  = nbit_r;
        chan_nxt_s  = chan_r;

        if (!en) begin
            presc_nxt_s = presc_r;
        end else if (tick_s) begin
            presc_nxt_s = {DW{1'b0}};
        end else begin
            presc_nxt_s = presc_r + DW'(1);
        end

        if (tick_s) begin
            phase_nxt_s = phase_wrap_s ? {PW{1'b0}} : phase_r + PW'(1);
        end else begin
            phase_nxt_s = phase_r;
        end

        if (tick_s && phase_wrap_s) begin
            nbit_nxt_s = nbit_wrap_s ? {BW{1'b0}} : nbit_r + BW'(1);
        end else begin
            nbit_nxt_s = nbit_r;
        end

        if (tick_s && phase_wrap_s && nbit_wrap_s) begin
            chan_nxt_s = chan_wrap_s ? {CW{1'b0}} : chan_r + CW'(1);
        end else begin
            chan_nxt_s = chan_r;
        end

        // A new mode takes effect together with the frame it starts.
        if (frame_wrap_s) begin
            mode_nxt_s = mode_map(mode);
        end else begin
            mode_nxt_s = mode_act_r;
        end

        bclk_nxt_s  = (phase_nxt_s >= PHASE_HIGH);
        lrclk_nxt_s = lrclk_decode(nbit_nxt_s, chan_nxt_s, mode_nxt_s);
    end

    // State and registered outputs; reset dominates enable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_r       <= {DW{1'b0}};
            phase_r       <= {PW{1'b0}};
            nbit_r        <= {BW{1'b0}};
            chan_r        <= {CW{1'b0}};
            phase_stb_r   <= 1'b0;
            frame_start_r <= 1'b0;
            bclk_r        <= 1'b0;
            mode_act_r    <= mode_map(mode);
            lrclk_r       <= lrclk_decode({BW{1'b0}}, {CW{1'b0}}, mode_map(mode));
        end else begin
            presc_r       <= presc_nxt_s;
            phase_r       <= phase_nxt_s;
            nbit_r        <= nbit_nxt_s;
            chan_r        <= chan_nxt_s;
            phase_stb_r   <= tick_s;
            frame_start_r <= frame_wrap_s;
            bclk_r        <= bclk_nxt_s;
            mode_act_r    <= mode_nxt_s;
            lrclk_r       <= lrclk_nxt_s;
        end
    end

    assign phase       = phase_r;
    assign nbit        = nbit_r;
    assign chan        = chan_r;
    assign phase_stb   = phase_stb_r;
    assign frame_start = frame_start_r;
    assign bclk        = bclk_r;
    assign lrclk       = lrclk_r;
    assign mode_act    = mode_act_r;

endmodule

// File: tb/tb_codec_frame_timer.sv
// Bench for codec_frame_timer: directed scenarios plus random en/mode/reset traffic,
// compared every cycle against a model built from enabled-cycle arithmetic.
module tb_codec_frame_timer;

    localparam int DIV = 3;
    localparam int P   = 4;
    localparam int B   = 4;
    localparam int C   = 2;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [1:0] phase;
    logic [1:0] nbit;
    logic       chan;
    logic       phase_stb;
    logic       frame_start;
    logic       bclk;
    logic       lrclk;
    logic [1:0] mode_act;

    codec_frame_timer #(
        .DIV(DIV), .PHASES(P), .BITS_PER_CH(B), .CHANNELS(C)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .phase(phase), .nbit(nbit), .chan(chan),
        .phase_stb(phase_stb), .frame_start(frame_start),
        .bclk(bclk), .lrclk(lrclk), .mode_act(mode_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: enabled cycles since reset release, plus the mode in force.
    int         m_e    = 0;
    logic [1:0] m_mode = 2'd1;
    logic       m_stb  = 1'b0;
    logic       m_fs   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [1:0] map_mode(input logic [1:0] m);
        return (m == 2'd3) ? 2'd1 : m;
    endfunction

    task automatic cyc(input logic r, input logic e, input logic [1:0] m);
        int t, k, ph, nb, ch, nch;
        logic lr;
        reset = r;
        en    = e;
        mode  = m;
        @(posedge clk);
        if (!r) begin
            m_e    = 0;
            m_mode = map_mode(m);
            m_stb  = 1'b0;
            m_fs   = 1'b0;
        end else if (e) begin
            m_e++;
            m_stb = ((m_e % DIV) == 0);
            m_fs  = m_stb && (((m_e / DIV) % (P * B * C)) == 0);
            if (m_fs) m_mode = map_mode(m);
        end else begin
            m_stb = 1'b0;
            m_fs  = 1'b0;
        end
        t   = m_e / DIV;
        ph  = t % P;
        k   = t / P;
        nb  = k % B;
        ch  = (k / B) % C;
        nch = ((k + 1) / B) % C;
        case (m_mode)
            2'd0:    lr = (nch % 2) == 1;
            2'd2:    lr = (ch == 0) && (nb == 0);
            default: lr = (ch % 2) == 1;
        endcase
        #1;
        check_eq("phase",       32'(phase),       32'(ph));
        check_eq("nbit",        32'(nbit),        32'(nb));
        check_eq("chan",        32'(chan),        32'(ch));
        check_eq("phase_stb",   32'(phase_stb),   32'(m_stb));
        check_eq("frame_start", 32'(frame_start), 32'(m_fs));
        check_eq("bclk",        32'(bclk),        (ph >= P / 2) ? 32'd1 : 32'd0);
        check_eq("lrclk",       32'(lrclk),       32'(lr));
        check_eq("mode_act",    32'(mode_act),    32'(m_mode));
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        mode  = 2'd1;
        // Left-justified run, switching to DSP mid-frame at clk 30.
        cyc(1'b0, 1'b1, 2'd1);
        cyc(1'b0, 1'b1, 2'd1);
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, (i < 30) ? 2'd1 : 2'd2);
        // I2S from reset, with a 7-cycle enable drop mid-bit.
        cyc(1'b0, 1'b1, 2'd0);
        for (int i = 0; i < 220; i++) cyc(1'b1, (i >= 100 && i < 107) ? 1'b0 : 1'b1, 2'd0);
        // DSP straight out of reset, reserved mode later.
        cyc(1'b0, 1'b0, 2'd2);
        for (int i = 0; i < 200; i++) cyc(1'b1, 1'b1, (i < 50) ? 2'd2 : 2'd3);
        // Reset mid-frame at chan=1, nbit=2 in LJ.
        cyc(1'b0, 1'b1, 2'd1);
        for (int i = 0; i < 48 * DIV / 3 + 24; i++) cyc(1'b1, 1'b1, 2'd1);
        cyc(1'b0, 1'b1, 2'd1);
        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic       r;
            logic       e;
            logic [1:0] m;
            r = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            e = ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0;
            m = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(0, 3)) : mode;
            cyc(r, e, m);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
